// File: rtl/ahb_pkg.sv
// Shared AHB encodings and burst-length helper used by the bus arbiters and wrappers.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_WRAP8  = 3'd4;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic [2:0] HBURST_WRAP16 = 3'd6;
  localparam logic [2:0] HBURST_INCR16 = 3'd7;

  localparam logic [1:0] HRESP_OKAY  = 2'd0;
  localparam logic [1:0] HRESP_ERROR = 2'd1;
  localparam logic [1:0] HRESP_RETRY = 2'd2;
  localparam logic [1:0] HRESP_SPLIT = 2'd3;

  // INCR is undefined length, so it is treated as a single protected beat.
  function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  burst_beats = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  burst_beats = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: burst_beats = 5'd16;
      default:                      burst_beats = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set req bit after 'last', wrapping to 'last' itself.
module rr_pick #(
  parameter int NUM_MASTERS = 4,
  parameter int MW = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [MW-1:0]          last,
  output logic                   valid,
  output logic [MW-1:0]          index
);

  logic [MW-1:0] cand;

  // Walk from farthest to nearest so the nearest requester is written last and wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int i = NUM_MASTERS; i >= 1; i--) begin
      cand = MW'((int'(last) + i) % NUM_MASTERS);
      if (req[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/ahb_tri_arbiter.sv
// Round-robin AHB arbiter with address/data-phase ownership tracking and
// registered active-low drive enables for the shared tri-state address and write-data buses.
module ahb_tri_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MW             = $clog2(NUM_MASTERS)
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HWRITE,
  input  logic                   HREADY,
  input  logic [1:0]             HRESP,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]          HMASTER,
  output logic [MW-1:0]          HMASTER_D,
  output logic                   HMASTLOCK,
  output logic [NUM_MASTERS-1:0] ADEN_n,
  output logic [NUM_MASTERS-1:0] WDEN_n
);

  localparam logic [MW-1:0] DEF_IDX = MW'(DEFAULT_MASTER);

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [MW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  logic [4:0]    rem;
  logic [4:0]    remNext;
  logic [MW-1:0] grantIdx;
  logic [MW-1:0] pickIdx;
  logic [MW-1:0] nextIdx;
  logic          pickValid;
  logic          accepted;
  logic          hold;

  rr_pick #(
    .NUM_MASTERS(NUM_MASTERS),
    .MW         (MW)
  ) u_pick (
    .req  (HBUSREQ),
    .last (grantIdx),
    .valid(pickValid),
    .index(pickIdx)
  );

  assign accepted = HREADY && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ));
  assign nextIdx  = pickValid ? pickIdx : DEF_IDX;

  // A non-OKAY response aborts the burst immediately, even in its first (HREADY=0) cycle.
  always_comb begin
    remNext = rem;
    if (HRESP != HRESP_OKAY)
      remNext = '0;
    else if (HREADY && (HTRANS == HTRANS_NONSEQ))
      remNext = burst_beats(HBURST) - 5'd1;
    else if (HREADY && (HTRANS == HTRANS_SEQ) && (rem != 5'd0))
      remNext = rem - 5'd1;
  end

  // Judged on the post-update count so the grant moves while the last beat is being
  // issued, letting the next owner's address phase follow with no dead cycle.
  assign hold = (HMASTLOCK && HLOCK[HMASTER]) || (remNext > 5'd1);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      HGRANT    <= onehot(DEF_IDX);
      grantIdx  <= DEF_IDX;
      HMASTER   <= DEF_IDX;
      HMASTER_D <= DEF_IDX;
      HMASTLOCK <= 1'b0;
      rem       <= '0;
      ADEN_n    <= '1;
      WDEN_n    <= '1;
    end else begin
      rem <= remNext;
      if (!hold) begin
        grantIdx <= nextIdx;
        HGRANT   <= onehot(nextIdx);
      end
      if (HREADY) begin
        HMASTER   <= grantIdx;
        HMASTLOCK <= HLOCK[grantIdx];
        ADEN_n    <= ~onehot(grantIdx);
        HMASTER_D <= HMASTER;
        WDEN_n    <= (accepted && HWRITE) ? ~onehot(HMASTER) : '1;
      end
    end
  end

endmodule
